// File: rtl/riscv_mem_pkg.sv
// ----------------------------------------------------------------------------
// riscv_mem_pkg
// Shared definitions for the data-memory responder:
//   - RISC-V load/store funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU)
//   - responder FSM state type (IDLE, WAIT, RESP)
//   - access_legal(): decides whether a request may touch the array
// ----------------------------------------------------------------------------
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    // A request is legal when exactly one of wr/rd is set, funct3 names a
    // real access size (unsigned variants only for loads) and the address is
    // naturally aligned for that size.
    function automatic logic access_legal(
        input logic       wr,
        input logic       rd,
        input logic [2:0] funct3,
        input logic [1:0] addr_lo
    );
        logic ok;
        ok = (wr != rd);
        case (funct3)
            F3_B:    ok = ok;
            F3_H:    ok = ok && !addr_lo[0];
            F3_W:    ok = ok && (addr_lo == 2'b00);
            F3_BU:   ok = ok && !wr;
            F3_HU:   ok = ok && !wr && !addr_lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// ----------------------------------------------------------------------------
// mem_lane_fmt
// Combinational byte-lane formatter for a little-endian 32-bit word array.
// Store path: byte enables from size/address, store data replicated onto
//             every lane so the enabled lanes pick up the right bytes.
// Load path:  byte/half selected from the word by address, then sign- or
//             zero-extended according to funct3.
// Ports:
//   i_st_funct3, i_st_addr_lo, i_st_data -> o_st_be, o_st_data
//   i_ld_funct3, i_ld_addr_lo, i_ld_word -> o_ld_data
// ----------------------------------------------------------------------------
module mem_lane_fmt
    import riscv_mem_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_addr_lo,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    always_comb begin
        o_st_be   = 4'b0000;
        o_st_data = i_st_data;
        case (i_st_funct3)
            F3_B: begin
                o_st_be   = 4'b0001 << i_st_addr_lo;
                o_st_data = {4{i_st_data[7:0]}};
            end
            F3_H: begin
                o_st_be   = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_st_data = {2{i_st_data[15:0]}};
            end
            F3_W: begin
                o_st_be = 4'b1111;
            end
            default: o_st_be = 4'b0000;
        endcase
    end

    always_comb begin
        case (i_ld_addr_lo)
            2'd0:    w_ld_byte = i_ld_word[7:0];
            2'd1:    w_ld_byte = i_ld_word[15:8];
            2'd2:    w_ld_byte = i_ld_word[23:16];
            default: w_ld_byte = i_ld_word[31:24];
        endcase
        w_ld_half = i_ld_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];

        case (i_ld_funct3)
            F3_B:    o_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            F3_H:    o_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            F3_W:    o_ld_data = i_ld_word;
            F3_BU:   o_ld_data = {24'd0, w_ld_byte};
            F3_HU:   o_ld_data = {16'd0, w_ld_half};
            default: o_ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the core's data port: a single-ported word array
// with RISC-V sub-word store merge and sign/zero load extraction, behind
// valid/ready request and response handshakes.
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready, wr, rd, addr, funct3, wr_data : request channel
//   rsp_valid/rsp_ready, rd_data, rsp_err              : response channel
//   dbg_state                                          : current FSM state
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// The sender holds its payload stable while valid is high and ready is low;
// the responder holds rsp_valid/rd_data/rsp_err until rsp_ready is seen.
// Timing: stores and illegal requests respond 1 cycle after accept, loads
// READ_LAT cycles after accept. Only one request is ever in flight.
// ----------------------------------------------------------------------------
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);

    localparam int         DEPTH  = 2 ** (ADDR_W - 2);
    localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];

    mem_state_e        r_state;
    logic [2:0]        r_cnt;
    logic              r_wr;
    logic              r_legal;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_req_legal;
    logic [3:0]        w_st_be;
    logic [31:0]       w_st_data;
    logic [31:0]       w_ld_word;
    logic [31:0]       w_ld_data;
    logic              w_done_wait;

    // Ready is gated by reset so it reads 0 while reset is held and 1 as soon
    // as reset is released with the FSM in IDLE.
    assign req_ready   = reset && (r_state == IDLE);
    assign w_accept    = req_valid && req_ready;
    assign w_req_legal = access_legal(wr, rd, funct3, addr[1:0]);

    assign rsp_valid = r_rsp_valid;
    assign rd_data   = r_rd_data;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

    // Stores use the live request fields because they commit on the accept
    // edge; loads use the latched fields when the latency count expires.
    assign w_ld_word = r_mem[r_addr[ADDR_W-1:2]];

    mem_lane_fmt u_lane_fmt (
        .i_st_funct3  (funct3),
        .i_st_addr_lo (addr[1:0]),
        .i_st_data    (wr_data),
        .o_st_be      (w_st_be),
        .o_st_data    (w_st_data),
        .i_ld_funct3  (r_funct3),
        .i_ld_addr_lo (r_addr[1:0]),
        .i_ld_word    (w_ld_word),
        .o_ld_data    (w_ld_data)
    );

    // Array contents survive reset; no write happens unless accepted & legal.
    always_ff @(posedge clk) begin
        if (w_accept && wr && w_req_legal) begin
            for (int i = 0; i < 4; i++) begin
                if (w_st_be[i]) begin
                    r_mem[addr[ADDR_W-1:2]][8*i +: 8] <= w_st_data[8*i +: 8];
                end
            end
        end
    end

    // Stores and illegal requests leave WAIT after one cycle; loads wait for
    // the counter to reach READ_LAT-1.
    assign w_done_wait = !r_legal || r_wr || (r_cnt == LAT_M1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_wr        <= 1'b0;
            r_legal     <= 1'b0;
            r_addr      <= '0;
            r_funct3    <= 3'd0;
            r_rsp_valid <= 1'b0;
            r_rd_data   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_wr     <= wr;
                        r_legal  <= w_req_legal;
                        r_addr   <= addr;
                        r_funct3 <= funct3;
                        r_cnt    <= 3'd0;
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_done_wait) begin
                        r_state     <= RESP;
                        r_cnt       <= 3'd0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= !r_legal;
                        r_rd_data   <= (r_legal && !r_wr) ? w_ld_data : '0;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rd_data   <= '0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
// Randomised and directed stimulus against a byte-array reference model.
// The driver pushes the model's expected response when a request is
// accepted; an independent monitor pops and compares whenever a response
// appears, and keeps checking it while the consumer stalls.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;
    import riscv_mem_pkg::*;

    localparam int RL    = 2;
    localparam int EXP_W = 36;   // {latency[2:0], err, data[31:0]}

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [8:0]  addr = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] wr_data = '0;
    logic        rsp_ready = 1'b1;
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rd_data;
    logic [1:0]  dbg_state;

    int cyc = 0;
    int n_vec = 0;
    int n_miss = 0;
    int bp_mode = 0;   // 0: always ready, 1: random, 2: never ready

    logic [EXP_W-1:0] exp_q[$];
    int               acc_q[$];
    logic [7:0]       ref_mem [512];

    bit               in_rsp = 1'b0;
    logic [31:0]      cur_data;
    logic             cur_err;
    logic [EXP_W-1:0] mon_e;
    int               mon_a;

    data_mem_responder #(.DATA_W(32), .ADDR_W(9), .READ_LAT(RL)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .wr        (wr),
        .rd        (rd),
        .addr      (addr),
        .funct3    (funct3),
        .wr_data   (wr_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rd_data   (rd_data),
        .rsp_err   (rsp_err),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        case (bp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = ($urandom_range(0, 3) != 0);
            default: rsp_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [EXP_W-1:0] model(input logic w, input logic r, input logic [2:0] f3,
                                               input logic [8:0] a, input logic [31:0] d);
        int          nb;
        bit          ok;
        logic [31:0] val;
        int          lat;
        case (f3)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            3'd2:       nb = 4;
            default:    nb = 0;
        endcase
        ok = (w != r) && (nb != 0) && !(w && f3 >= 3'd4);
        if (ok && (int'(a) % nb) != 0) ok = 1'b0;
        val = '0;
        if (ok && w) begin
            for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
        end else if (ok) begin
            for (int i = 0; i < nb; i++) val[8*i +: 8] = ref_mem[int'(a) + i];
            if (f3 < 3'd4 && nb < 4 && val[8*nb-1]) begin
                for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
            end
        end
        lat = (ok && r) ? RL : 1;
        return {3'(lat), !ok, val};
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic w, input logic r, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] d, input bit expect_rsp);
        bit got;
        got = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        wr = w; rd = r; funct3 = f3; addr = a; wr_data = d;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout: req_ready never rose for addr 0x%03h", a);
            req_valid = 1'b0;
        end else begin
            if (expect_rsp) begin
                exp_q.push_back(model(w, r, f3, a, d));
                acc_q.push_back(cyc + 1);
            end
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !rsp_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            in_rsp = 1'b0;
        end else if (rsp_valid) begin
            if (!in_rsp) begin
                in_rsp = 1'b1;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_rsp: actual data 0x%08h err %0d, required no response",
                             rd_data, rsp_err);
                    cur_data = rd_data;
                    cur_err  = rsp_err;
                end else begin
                    mon_e    = exp_q.pop_front();
                    mon_a    = acc_q.pop_front();
                    cur_data = mon_e[31:0];
                    cur_err  = mon_e[32];
                    chk("rsp_data", rd_data, cur_data);
                    chk("rsp_err", 32'(rsp_err), 32'(cur_err));
                    chk("rsp_latency", 32'(cyc - mon_a), 32'(mon_e[35:33]));
                end
            end else begin
                chk("hold_data", rd_data, cur_data);
                chk("hold_err", 32'(rsp_err), 32'(cur_err));
            end
            if (rsp_ready) in_rsp = 1'b0;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          got;
        logic        w;
        logic        r;
        logic [2:0]  f3;
        logic [8:0]  a;
        int          k;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b1;
        #1;
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        // Fill every word so later loads read known data.
        bp_mode = 1;
        for (int i = 0; i < 128; i++) issue(1'b0 + 1'b1, 1'b0, F3_W, 9'(i * 4), $urandom(), 1'b1);
        drain();

        // Directed store-merge / extract sequence
        bp_mode = 0;
        issue(1, 0, F3_W,  9'h010, 32'hDEADBEEF, 1);
        issue(0, 1, F3_W,  9'h010, 32'h0, 1);
        issue(1, 0, F3_B,  9'h012, 32'h0000005A, 1);
        issue(0, 1, F3_W,  9'h010, 32'h0, 1);
        issue(0, 1, F3_B,  9'h012, 32'h0, 1);
        issue(0, 1, F3_B,  9'h013, 32'h0, 1);
        issue(0, 1, F3_BU, 9'h013, 32'h0, 1);
        issue(1, 0, F3_H,  9'h022, 32'h00008001, 1);
        issue(0, 1, F3_H,  9'h022, 32'h0, 1);
        issue(0, 1, F3_HU, 9'h022, 32'h0, 1);
        issue(0, 1, F3_H,  9'h021, 32'h0, 1);
        issue(0, 1, F3_W,  9'h020, 32'h0, 1);
        // Illegal requests: no write must land
        issue(1, 1, F3_W,  9'h030, 32'h12345678, 1);
        issue(1, 0, 3'd3,  9'h030, 32'h12345678, 1);
        issue(1, 0, F3_W,  9'h003, 32'h12345678, 1);
        issue(1, 0, F3_BU, 9'h031, 32'h12345678, 1);
        issue(0, 0, F3_W,  9'h030, 32'h0, 1);
        issue(0, 1, F3_W,  9'h030, 32'h0, 1);
        issue(0, 1, F3_W,  9'h000, 32'h0, 1);
        drain();

        // Consumer stall: response held, new request refused
        bp_mode = 2;
        repeat (2) @(negedge clk);
        issue(0, 1, F3_W, 9'h010, 32'h0, 1);
        got = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_miss++;
            $display("FAIL stall_rsp_timeout: rsp_valid never rose");
        end
        req_valid = 1'b1; wr = 1'b0; rd = 1'b1; funct3 = F3_BU; addr = 9'h013;
        for (int j = 0; j < 5; j++) begin
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            @(negedge clk);
            #1;
        end
        bp_mode = 0;
        issue(0, 1, F3_BU, 9'h013, 32'h0, 1);
        drain();

        // Reset during a load's WAIT: response dropped, array retained
        issue(0, 1, F3_W, 9'h010, 32'h0, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b1;
        #1;
        chk("midrst_rel_ready", 32'(req_ready), 32'd1);
        repeat (6) begin
            @(negedge clk);
            #1;
            chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        issue(0, 1, F3_W, 9'h010, 32'h0, 1);
        issue(0, 1, F3_H, 9'h022, 32'h0, 1);
        drain();

        // Randomised traffic with random back-pressure
        bp_mode = 1;
        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 15);
            if (k == 0) begin
                w = 1'b1; r = 1'b1;
            end else if (k == 1) begin
                w = 1'b0; r = 1'b0;
            end else begin
                w = 1'($urandom_range(0, 1)); r = !w;
            end
            case ($urandom_range(0, 5))
                0:       f3 = F3_B;
                1:       f3 = F3_H;
                2:       f3 = F3_W;
                3:       f3 = F3_BU;
                4:       f3 = F3_HU;
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            a = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) begin
                if (f3 == F3_W) a[1:0] = 2'b00;
                else if (f3 == F3_H || f3 == F3_HU) a[0] = 1'b0;
            end
            issue(w, r, f3, a, $urandom(), 1'b1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
